de10lite_mlp_computer_qsys_keys_in: RTL

Avalon-MM slave parallel input port for the DE10-Lite MLP computer. It samples the board pushbuttons (or any slow external inputs) through a synchronizer and a per-bit debouncer, and latches edges in a capture register. It raises a maskable level interrupt to the Nios II. It is the read-direction counterpart of the hex display output ports and sits on the same system interconnect, with the same register-style software view.

---
 rtl/de10lite_mlp_pio_pkg.sv | 27 ++
 rtl/pio_in_debounce.sv | 57 +++++
 rtl/de10lite_mlp_computer_qsys_keys_in.sv | 86 ++++++++
 3 files changed

// File: rtl/de10lite_mlp_pio_pkg.sv
// Shared definitions for the DE10-Lite MLP computer parallel I/O ports:
// register map, edge-capture encodings and small elaboration helpers.
package de10lite_mlp_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int unsigned EDGE_FALL = 0;
  localparam int unsigned EDGE_RISE = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Unknown encodings fall back to capturing any edge rather than none.
  function automatic logic edge_hit(int unsigned edge_type, logic rise, logic fall);
    case (edge_type)
      EDGE_FALL: return fall;
      EDGE_RISE: return rise;
      default:   return rise | fall;
    endcase
  endfunction

  function automatic int unsigned cnt_width(int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// Single-bit two-flop synchronizer and debounce counter; reports the accepted
// level plus one-cycle rise/fall pulses aligned with the edge that updates deb.
module pio_in_debounce
  import de10lite_mlp_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             settle;

  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    settle = (sync2_q != deb_q) && (cnt_q == CNT_LAST);
    // Any sample matching deb drops the count back to zero.
    if (sync2_q != deb_q) begin
      if (settle) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      deb_q   <= IDLE_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb  = deb_q;
  assign rise = settle & sync2_q;
  assign fall = settle & ~sync2_q;

endmodule

// File: rtl/de10lite_mlp_computer_qsys_keys_in.sv
// Avalon-MM parallel input port: debounced inputs, edge capture register with
// write-1-to-clear, interrupt mask and a level irq to the processor.
module de10lite_mlp_computer_qsys_keys_in
  import de10lite_mlp_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 2,
  parameter int unsigned           DEBOUNCE_CYCLES = 500000,
  parameter logic [DATA_WIDTH-1:0] IDLE_LEVEL      = '1,
  parameter int unsigned           EDGE_TYPE       = EDGE_FALL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] deb, rise, fall, new_edge;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [DATA_WIDTH-1:0] clear_bits;
  logic                  wr_en;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL[i])
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .deb    (deb[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  if (DATA_WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:DATA_WIDTH];
  end

  always_comb begin
    wr_en      = chipselect & ~write_n;
    irq_mask_d = irq_mask_q;
    clear_bits = '0;
    if (wr_en && (address == ADDR_IRQ_MASK)) begin
      irq_mask_d = writedata[DATA_WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE_CAP)) begin
      clear_bits = writedata[DATA_WIDTH-1:0];
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      new_edge[i] = edge_hit(EDGE_TYPE, rise[i], fall[i]);
    end
    // A fresh edge outranks a simultaneous clear so no event is lost.
    edge_cap_d = (edge_cap_q & ~clear_bits) | new_edge;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[DATA_WIDTH-1:0] = deb;
      ADDR_IRQ_MASK: readdata[DATA_WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata[DATA_WIDTH-1:0] = edge_cap_q;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule
